// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the in-order pipeline
// writeback stage and an out-of-order multiply/divide unit (MDU). MDU results
// are queued in a small FIFO. A 32-bit pending scoreboard stalls decode on
// hazards against outstanding MDU destinations. A wait counter bounds how long
// the FIFO head can be starved by pipeline writes.
// Optional statistics: define REGFILE_ARB_STATS_EN to enable the saturating
// write-port conflict counter; otherwise conflict_cnt is tied to zero.
module regfile_wb_arbiter #(
    parameter int DEPTH    = 4,   // MDU result FIFO entries, power of two 2..16
    parameter int MAX_WAIT = 8    // blocked cycles before the pipeline is held
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb,
    input  logic [4:0]  pipe_wreg,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_hold,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_wreg,
    input  logic [31:0] mdu_wdata,
    output logic        mdu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wreg,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [4:0]  dst,
    output logic        stall,
    output logic        WB,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic [15:0] conflict_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_PIPE,
        GNT_MDU
    } grant_e;

    grant_e          grant;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      mem_reg_q  [DEPTH];
    logic [31:0]     mem_data_q [DEPTH];
    logic [WW-1:0]   wait_q, wait_d;
    logic [31:0]     pending_q, pending_d;
    logic            wb_q, wb_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            fifo_empty, fifo_full, push, pop;
    logic [4:0]      head_reg;
    logic [31:0]     head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    // Full is judged before any pop this cycle, so a push into a full FIFO is
    // refused even when the head is leaving on the same edge.
    assign mdu_ready  = !fifo_full;
    assign push       = mdu_valid && !fifo_full;
    assign pipe_hold  = (wait_q == WW'(MAX_WAIT));
    assign head_reg   = mem_reg_q[rd_ptr_q];
    assign head_data  = mem_data_q[rd_ptr_q];
    assign pop        = (grant == GNT_MDU);

    assign stall = pending_q[src1] | pending_q[src2] | pending_q[dst]
                 | (issue_valid && fifo_full);

    assign WB        = wb_q;
    assign writeReg  = wreg_q;
    assign writeData = wdata_q;

    // Write-port grant: pipeline first unless held for a starved FIFO head.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = GNT_IDLE;
        if (pipe_wb && !pipe_hold) begin
            grant = GNT_PIPE;
        end else if (!fifo_empty) begin
            grant = GNT_MDU;
        end
    end

    // Next-state for the write register, wait counter, scoreboard and FIFO pointers.
    always_comb begin
        wb_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        wait_d    = '0;
        pending_d = pending_q;
        unique case (grant)
            GNT_PIPE: begin
                wb_d    = (pipe_wreg != 5'd0);
                wreg_d  = pipe_wreg;
                wdata_d = pipe_wdata;
                wait_d  = fifo_empty ? '0 : wait_q + WW'(1);
            end
            GNT_MDU: begin
                wb_d    = (head_reg != 5'd0);
                wreg_d  = head_reg;
                wdata_d = head_data;
                pending_d[head_reg] = 1'b0;
            end
            default: ;
        endcase
        // Applied after the clear: a newly issued op to the same register stays pending.
        if (issue_valid && issue_wreg != 5'd0) begin
            pending_d[issue_wreg] = 1'b1;
        end
        pending_d[0] = 1'b0;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            pending_q <= '0;
            wb_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            wb_q      <= wb_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
        end
    end

    // FIFO storage written on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the count register alone says which entries are live.
        if (push) begin
            mem_reg_q[wr_ptr_q]  <= mdu_wreg;
            mem_data_q[wr_ptr_q] <= mdu_wdata;
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_q;

    // Saturating count of cycles where both writers want the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (pipe_wb && !fifo_empty && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb;
    logic [4:0]  pipe_wreg;
    logic [31:0] pipe_wdata;
    logic        pipe_hold;
    logic        mdu_valid;
    logic [4:0]  mdu_wreg;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_wreg;
    logic [4:0]  src1, src2, dst;
    logic        stall;
    logic        WB;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [15:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_wb(pipe_wb), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata), .pipe_hold(pipe_hold),
        .mdu_valid(mdu_valid), .mdu_wreg(mdu_wreg), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_wreg(issue_wreg),
        .src1(src1), .src2(src2), .dst(dst), .stall(stall),
        .WB(WB), .writeReg(writeReg), .writeData(writeData), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit [31:0]   m_pend;
    int          m_wait;
    bit          m_wb;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    int          m_cnt;

    function automatic bit m_hold();
        return m_wait == MAX_WAIT;
    endfunction

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction

    function automatic bit m_stall();
        return m_pend[src1] | m_pend[src2] | m_pend[dst] | (issue_valid && m_full());
    endfunction

    function automatic int exp_conflict();
`ifdef REGFILE_ARB_STATS_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        bit   was_full, pipe_go;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pend = '0; m_wait = 0; m_wb = 0; m_wreg = '0; m_wdata = '0; m_cnt = 0;
            return;
        end
        was_full = m_full();
        if (pipe_wb && mq.size() > 0 && m_cnt < 65535) m_cnt++;
        pipe_go = pipe_wb && !m_hold();
        m_wb = 0;
        if (pipe_go) begin
            m_wb = (pipe_wreg != 0); m_wreg = pipe_wreg; m_wdata = pipe_wdata;
            m_wait = (mq.size() > 0) ? m_wait + 1 : 0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wb = (e.r != 0); m_wreg = e.r; m_wdata = e.d;
            m_wait = 0;
            m_pend[e.r] = 1'b0;
        end else begin
            m_wait = 0;
        end
        if (mdu_valid && !was_full) begin
            e.r = mdu_wreg; e.d = mdu_wdata;
            mq.push_back(e);
        end
        if (issue_valid && issue_wreg != 0) m_pend[issue_wreg] = 1'b1;
    endtask

    // One clock: update the model, then land 2 time units after the edge.
    task automatic tick();
        model_update();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        pipe_wb = 0; pipe_wreg = '0; pipe_wdata = '0;
        mdu_valid = 0; mdu_wreg = '0; mdu_wdata = '0;
        issue_valid = 0; issue_wreg = '0;
        src1 = '0; src2 = '0; dst = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        checks++; if (WB !== 1'b0) begin errors++; $display("FAIL reset_wb got=%b exp=0", WB); end
        checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_wreg got=%0d exp=0", writeReg); end
        checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", writeData); end
        checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", pipe_hold); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", mdu_ready); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_conflict got=%0d exp=0", conflict_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end

        // Load two FIFO entries and pending[9], then reset mid-operation.
        issue_valid = 1; issue_wreg = 5'd9;
        pipe_wb = 1; pipe_wreg = 5'd1; pipe_wdata = 32'h11;
        mdu_valid = 1; mdu_wreg = 5'd2; mdu_wdata = 32'h22;
        #1; tick();
        issue_valid = 0;
        mdu_wreg = 5'd3; mdu_wdata = 32'h33;
        #1; tick();
        mdu_valid = 0; src1 = 5'd9;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
        rst = 1;
        tick();
        rst = 0; pipe_wb = 0;
        #1;
        checks++; if (WB !== 1'b0) begin errors++; $display("FAIL midreset_wb got=%b exp=0", WB); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got=%b exp=0", stall); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", mdu_ready); end
        tick();
        #1;
        checks++; if (WB !== 1'b0) begin errors++; $display("FAIL midreset_discard got=%b exp=0", WB); end
        drive_idle();
    endtask

    task automatic test_pipe_only();
        do_reset();
        pipe_wb = 1; pipe_wreg = 5'd9; pipe_wdata = 32'd5;
        #1; tick();
        pipe_wb = 0;
        #1;
        checks++; if ({WB, writeReg, writeData} !== {1'b1, 5'd9, 32'd5}) begin
            errors++; $display("FAIL pipe_write got=%b/%0d/%0d exp=1/9/5", WB, writeReg, writeData);
        end
        tick();
        #1;
        checks++; if (WB !== 1'b0) begin errors++; $display("FAIL pipe_idle got=%b exp=0", WB); end
    endtask

    task automatic test_hazard();
        do_reset();
        issue_valid = 1; issue_wreg = 5'd10;
        #1; tick();
        issue_valid = 0; src1 = 5'd10;
        mdu_valid = 1; mdu_wreg = 5'd10; mdu_wdata = 32'd12;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_stall got=%b exp=1", stall); end
        tick();
        mdu_valid = 0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_grant_stall got=%b exp=1", stall); end
        tick();
        #1;
        checks++; if ({WB, writeReg, writeData} !== {1'b1, 5'd10, 32'd12}) begin
            errors++; $display("FAIL hazard_write got=%b/%0d/%0d exp=1/10/12", WB, writeReg, writeData);
        end
        tick();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hazard_release got=%b exp=0", stall); end
        drive_idle();
    endtask

    task automatic test_contention();
        do_reset();
        pipe_wb = 1; pipe_wreg = 5'd3; pipe_wdata = $urandom;
        mdu_valid = 1; mdu_wreg = 5'd11; mdu_wdata = 32'h77;
        #1; tick();
        mdu_valid = 0;
        for (int k = 1; k <= 9; k++) begin
            pipe_wdata = $urandom;
            #1;
            checks++; if (pipe_hold !== (k == 9)) begin
                errors++; $display("FAIL contention_hold cycle=%0d got=%b exp=%b", k, pipe_hold, (k == 9));
            end
            tick();
        end
        #1;
        checks++; if ({WB, writeReg, writeData} !== {1'b1, 5'd11, 32'h77}) begin
            errors++; $display("FAIL contention_write got=%b/%0d/%h exp=1/11/77", WB, writeReg, writeData);
        end
        checks++; if (pipe_hold !== 1'b0) begin errors++; $display("FAIL contention_release got=%b exp=0", pipe_hold); end
`ifdef REGFILE_ARB_STATS_EN
        checks++; if (conflict_cnt !== 16'd9) begin errors++; $display("FAIL contention_cnt got=%0d exp=9", conflict_cnt); end
`else
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL contention_cnt got=%0d exp=0", conflict_cnt); end
`endif
        drive_idle();
    endtask

    task automatic test_fifo_full();
        logic [4:0]  exp_r[4];
        logic [31:0] exp_d[4];
        int got;
        do_reset();
        pipe_wb = 1; pipe_wreg = 5'd1;
        for (int i = 0; i < 4; i++) begin
            exp_r[i] = 5'(20 + i); exp_d[i] = $urandom;
            mdu_valid = 1; mdu_wreg = exp_r[i]; mdu_wdata = exp_d[i];
            pipe_wdata = $urandom;
            #1;
            checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready idx=%0d got=%b exp=1", i, mdu_ready); end
            tick();
        end
        // Full FIFO: pop and refused push on the same edge.
        pipe_wb = 0;
        mdu_valid = 1; mdu_wreg = 5'd24; mdu_wdata = 32'hDEAD;
        issue_valid = 1; issue_wreg = 5'd0;
        #1;
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", mdu_ready); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", stall); end
        tick();
        mdu_valid = 0; issue_valid = 0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (WB === 1'b1) begin
                checks++;
                if (got >= 4) begin
                    errors++; $display("FAIL drain_extra got=%0d exp=none", writeReg);
                end else if ({writeReg, writeData} !== {exp_r[got], exp_d[got]}) begin
                    errors++; $display("FAIL drain_order idx=%0d got=%0d/%h exp=%0d/%h", got, writeReg, writeData, exp_r[got], exp_d[got]);
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 4) begin errors++; $display("FAIL drain_count got=%0d exp=4", got); end
        drive_idle();
    endtask

    task automatic test_dest_zero();
        do_reset();
        issue_valid = 1; issue_wreg = 5'd13;
        #1; tick();
        issue_valid = 0;
        mdu_valid = 1; mdu_wreg = 5'd0; mdu_wdata = 32'hABC;
        #1; tick();
        mdu_wreg = 5'd14; mdu_wdata = 32'hDEF; src1 = 5'd13;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zero_pending got=%b exp=1", stall); end
        tick();
        mdu_valid = 0;
        #1;
        checks++; if (WB !== 1'b0) begin errors++; $display("FAIL zero_wb got=%b exp=0", WB); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zero_keep_pending got=%b exp=1", stall); end
        tick();
        #1;
        checks++; if ({WB, writeReg, writeData} !== {1'b1, 5'd14, 32'hDEF}) begin
            errors++; $display("FAIL zero_next got=%b/%0d/%h exp=1/14/def", WB, writeReg, writeData);
        end
        src1 = 5'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_operand got=%b exp=0", stall); end
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            pipe_wb     = ($urandom_range(0, 99) < 55);
            pipe_wreg   = 5'($urandom_range(0, 31));
            pipe_wdata  = $urandom;
            mdu_valid   = ($urandom_range(0, 99) < 40);
            mdu_wreg    = 5'($urandom_range(0, 31));
            mdu_wdata   = $urandom;
            issue_valid = ($urandom_range(0, 99) < 25);
            issue_wreg  = 5'($urandom_range(0, 31));
            src1        = 5'($urandom_range(0, 31));
            src2        = 5'($urandom_range(0, 31));
            dst         = 5'($urandom_range(0, 31));
            #1;
            checks++; if (WB !== m_wb) begin errors++; $display("FAIL rnd_wb n=%0d got=%b exp=%b", n, WB, m_wb); end
            if (m_wb) begin
                checks++; if ({writeReg, writeData} !== {m_wreg, m_wdata}) begin
                    errors++; $display("FAIL rnd_write n=%0d got=%0d/%h exp=%0d/%h", n, writeReg, writeData, m_wreg, m_wdata);
                end
            end
            checks++; if (pipe_hold !== m_hold()) begin errors++; $display("FAIL rnd_hold n=%0d got=%b exp=%b", n, pipe_hold, m_hold()); end
            checks++; if (mdu_ready !== !m_full()) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, mdu_ready, !m_full()); end
            checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, m_stall()); end
            checks++; if (conflict_cnt !== 16'(exp_conflict())) begin
                errors++; $display("FAIL rnd_conflict n=%0d got=%0d exp=%0d", n, conflict_cnt, exp_conflict());
            end
            tick();
        end
        rst = 0;
        drive_idle();
    endtask

    initial begin
        rst = 1;
        drive_idle();
        #2;
        test_reset();
        test_pipe_only();
        test_hazard();
        test_contention();
        test_fifo_full();
        test_dest_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
